// File: rtl/beam_pkg.sv
// Shared types and helpers for the beam power accumulator.
package beam_pkg;

    localparam int BEAM_COL = 64;
    localparam int BEAM_IW  = 32;
    localparam int BEAM_DW  = 16;
    localparam int ACC_MAX  = 4096;

    typedef logic [2*BEAM_DW-1:0] iq_t;
    typedef logic [BEAM_IW-1:0]   pwr_t;

    typedef enum logic {ST_ACC, ST_WAIT} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Shift right, then clamp to the all-ones value of a w-bit result (w < 64).
    function automatic logic [63:0] sat_shr(input logic [63:0] v, input int sh, input int w);
        logic [63:0] s;
        s = v >> sh;
        if ((s >> w) != 64'd0) s = (64'd1 << w) - 64'd1;
        return s;
    endfunction

endpackage

// File: rtl/beam_power_lane.sv
// One beam: square, sum, accumulate, then scale/saturate into the output hold.
module beam_power_lane
    import beam_pkg::*;
#(
    parameter int IW    = BEAM_IW,
    parameter int DW    = BEAM_DW,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            acc_en,
    input  logic            acc_first,
    input  logic            hold_load,
    input  logic [2*DW-1:0] iq,
    output logic [IW-1:0]   pwr
);

    localparam int AW = 2*DW + 1 + clog2(ACC_MAX);

    logic signed [2*DW-1:0] i_ext, q_ext, i_sq, q_sq;
    logic [2*DW-1:0]        sq_i, sq_q;
    logic [2*DW:0]          sum;
    logic [AW-1:0]          acc;

    assign i_ext = {{DW{iq[2*DW-1]}}, iq[2*DW-1:DW]};
    assign q_ext = {{DW{iq[DW-1]}}, iq[DW-1:0]};
    assign i_sq  = i_ext * i_ext;
    assign q_sq  = q_ext * q_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq_i <= '0;
            sq_q <= '0;
            sum  <= '0;
            acc  <= '0;
            pwr  <= '0;
        end else begin
            if (en) begin
                sq_i <= i_sq;
                sq_q <= q_sq;
                sum  <= {1'b0, sq_i} + {1'b0, sq_q};
            end
            if (acc_en)
                acc <= acc_first ? AW'(sum) : acc + AW'(sum);
            // acc still holds the finished block here even if it reloads this edge
            if (hold_load)
                pwr <= IW'(sat_shr(64'(acc), SHIFT, IW));
        end
    end

endmodule

// File: rtl/beam_power_acc.sv
// COL-wide I^2+Q^2 accumulator with a single output hold and valid/ready handshake.
module beam_power_acc
    import beam_pkg::*;
#(
    parameter int IW      = BEAM_IW,
    parameter int COL     = BEAM_COL,
    parameter int DW      = BEAM_DW,
    parameter int ACC_LEN = 12,
    parameter int SHIFT   = 0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [COL-1:0][2*DW-1:0]   i_iq,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [COL-1:0][IW-1:0]     o_data,
    output logic                       o_rvalid,
    input  logic                       i_tready
);

    localparam int CW = clog2(ACC_LEN) + 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:1]    vld_pipe, last_pipe;
    logic [2:1]    first_pipe;
    logic          accept, res_rdy, load, en, acc_en, busy_next, go_wait, cnt_last;

    assign accept   = i_valid && o_ready;
    assign cnt_last = (cnt == CW'(ACC_LEN - 1));
    assign res_rdy  = vld_pipe[3] && last_pipe[3];
    assign load     = res_rdy && (!o_rvalid || i_tready);
    assign en       = (state == ST_ACC) || load;
    assign acc_en   = en && vld_pipe[2];
    // Stall is decided one stage early so a sample accepted this cycle is never lost.
    assign busy_next = load || (o_rvalid && !i_tready);
    assign go_wait   = en && vld_pipe[2] && last_pipe[2] && busy_next;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state      <= ST_ACC;
            o_ready    <= 1'b1;
            o_rvalid   <= 1'b0;
            cnt        <= '0;
            vld_pipe   <= '0;
            last_pipe  <= '0;
            first_pipe <= '0;
        end else begin
            if (en) begin
                vld_pipe   <= {vld_pipe[2:1], accept};
                last_pipe  <= {last_pipe[2:1], cnt_last};
                first_pipe <= {first_pipe[1], cnt == '0};
            end
            if (accept)
                cnt <= cnt_last ? '0 : cnt + CW'(1);
            if (load)
                o_rvalid <= 1'b1;
            else if (i_tready)
                o_rvalid <= 1'b0;
            case (state)
                ST_ACC:
                    if (go_wait) begin
                        state   <= ST_WAIT;
                        o_ready <= 1'b0;
                    end
                ST_WAIT:
                    if (en) begin
                        state   <= go_wait ? ST_WAIT : ST_ACC;
                        o_ready <= !go_wait;
                    end
                default: begin
                    state   <= ST_ACC;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar b = 0; b < COL; b++) begin : g_lane
        beam_power_lane #(.IW(IW), .DW(DW), .SHIFT(SHIFT)) u_lane (
            .clk       (i_clk),
            .rst_n     (i_reset),
            .en        (en),
            .acc_en    (acc_en),
            .acc_first (first_pipe[2]),
            .hold_load (load),
            .iq        (i_iq[b]),
            .pwr       (o_data[b])
        );
    end

endmodule

// File: tb/tb_beam_power_acc.sv
// Bench: two DUTs (SHIFT 0 and 2) on shared stimulus, checked against a block-sum scoreboard.
module tb_beam_power_acc;

    localparam int COL = 64, IW = 32, DW = 16, ACC_LEN = 4;
    typedef logic [COL-1:0][IW-1:0] pvec_t;

    logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_tready = 1'b1;
    logic [COL-1:0][2*DW-1:0] iq = '0;
    logic  ready0, ready2, rvalid0, rvalid2;
    pvec_t data0, data2;

    int n_tests = 0, n_fail = 0, n_acc = 0, n_xfer = 0;

    longint unsigned sums[COL];
    int    blk = 0;
    pvec_t q0[$], q2[$];

    always #5 clk = ~clk;

    beam_power_acc #(.IW(IW), .COL(COL), .DW(DW), .ACC_LEN(ACC_LEN), .SHIFT(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_iq(iq), .i_valid(i_valid), .o_ready(ready0),
        .o_data(data0), .o_rvalid(rvalid0), .i_tready(i_tready));

    beam_power_acc #(.IW(IW), .COL(COL), .DW(DW), .ACC_LEN(ACC_LEN), .SHIFT(2)) u_dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_iq(iq), .i_valid(i_valid), .o_ready(ready2),
        .o_data(data2), .o_rvalid(rvalid2), .i_tready(i_tready));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] scale(input longint unsigned s, input int sh);
        longint unsigned v;
        v = s >> sh;
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    // Scoreboard: whole-block sums per beam, one expected vector per finished block.
    always @(negedge clk) begin
        longint iv, qv;
        pvec_t  e0, e2;
        if (!rst_n) begin
            q0.delete();
            q2.delete();
            blk = 0;
            foreach (sums[b]) sums[b] = 0;
        end else begin
            if (rvalid0) begin
                if (q0.size() == 0) check("rvalid0_unexpected", 1, 0);
                else begin
                    for (int b = 0; b < COL; b++)
                        check($sformatf("data0[%0d]", b), 64'(data0[b]), 64'(q0[0][b]));
                    if (i_tready) begin
                        void'(q0.pop_front());
                        n_xfer++;
                    end
                end
            end
            if (rvalid2) begin
                if (q2.size() == 0) check("rvalid2_unexpected", 1, 0);
                else begin
                    for (int b = 0; b < COL; b++)
                        check($sformatf("data2[%0d]", b), 64'(data2[b]), 64'(q2[0][b]));
                    if (i_tready) void'(q2.pop_front());
                end
            end
            if (i_valid && ready0) begin
                n_acc++;
                for (int b = 0; b < COL; b++) begin
                    iv = $signed(iq[b][2*DW-1:DW]);
                    qv = $signed(iq[b][DW-1:0]);
                    sums[b] += longint'(iv * iv + qv * qv);
                end
                blk++;
                if (blk == ACC_LEN) begin
                    for (int b = 0; b < COL; b++) begin
                        e0[b] = scale(sums[b], 0);
                        e2[b] = scale(sums[b], 2);
                        sums[b] = 0;
                    end
                    q0.push_back(e0);
                    q2.push_back(e2);
                    blk = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int i, input int q);
        for (int b = 0; b < COL; b++) iq[b] = {DW'(i), DW'(q)};
    endtask

    task automatic send();
        logic r;
        i_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            r = ready0;
            tick();
            if (r) begin
                i_valid = 1'b0;
                return;
            end
        end
        i_valid = 1'b0;
        check("send_timeout", 0, 1);
    endtask

    task automatic send_n(input int n);
        for (int k = 0; k < n; k++) send();
    endtask

    task automatic wait_rv(output int cyc);
        cyc = 0;
        while (!rvalid0 && cyc < 30) begin
            tick();
            cyc++;
        end
        if (!rvalid0) check("rvalid_timeout", 0, 1);
    endtask

    initial begin
        int cyc, a0, x0;
        logic pat[7] = '{1, 0, 0, 1, 0, 1, 1};

        repeat (3) tick();
        check("rst_rvalid", 64'(rvalid0), 0);
        check("rst_ready", 64'(ready0), 1);
        check("rst_data0", 64'(data0[0]), 0);
        check("rst_data63", 64'(data0[COL-1]), 0);
        rst_n = 1'b1;
        tick();

        // 3,4 on every beam: 100 per beam, one-cycle valid at +4
        set_all(3, 4);
        send_n(4);
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("lat_rvalid_%0d", k), 64'(rvalid0), 64'(k == 3));
            if (k == 3) begin
                check("t1_data0", 64'(data0[0]), 100);
                check("t1_data63", 64'(data0[COL-1]), 100);
                check("t1_shift2", 64'(data2[0]), 25);
            end
            tick();
        end

        // beam index as I, then negated
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < COL; b++) iq[b] = {DW'(s == 0 ? b : -b), DW'(0)};
            send_n(4);
            wait_rv(cyc);
            check("beam0", 64'(data0[0]), 0);
            check("beam63", 64'(data0[COL-1]), 15876);
            repeat (2) tick();
        end

        // most-negative components: saturation, and exact with SHIFT=2
        set_all(-32768, -32768);
        send_n(4);
        wait_rv(cyc);
        check("ext_sat", 64'(data0[5]), 64'h0000_0000_FFFF_FFFF);
        check("ext_shift2", 64'(data2[5]), 64'h0000_0000_8000_0000);
        repeat (2) tick();

        // backpressure with two queued blocks
        i_tready = 1'b0;
        a0 = n_acc;
        set_all(3, 4);
        send_n(4);
        set_all(6, 8);
        send_n(4);
        repeat (4) tick();
        check("bp_ready_low", 64'(ready0), 0);
        check("bp_rvalid", 64'(rvalid0), 1);
        check("bp_held", 64'(data0[0]), 100);
        x0 = n_xfer;
        i_tready = 1'b1;
        tick();
        tick();
        i_tready = 1'b0;
        check("bp_xfers", 64'(n_xfer - x0), 2);
        check("bp_ready_back", 64'(ready0), 1);
        check("bp_rvalid_off", 64'(rvalid0), 0);
        check("bp_accepts", 64'(n_acc - a0), 8);
        i_tready = 1'b1;
        tick();

        // i_valid gaps
        set_all(1, 1);
        foreach (pat[k]) begin
            i_valid = pat[k];
            check($sformatf("gap_ready_%0d", k), 64'(ready0), 1);
            check($sformatf("gap_rvalid_%0d", k), 64'(rvalid0), 0);
            tick();
        end
        i_valid = 1'b0;
        wait_rv(cyc);
        check("gap_latency", 64'(cyc), 3);
        check("gap_data", 64'(data0[0]), 8);
        repeat (2) tick();

        // reset mid-block
        set_all(9, 9);
        send_n(2);
        rst_n = 1'b0;
        tick();
        check("mrst_rvalid", 64'(rvalid0), 0);
        check("mrst_data", 64'(data0[0]), 0);
        rst_n = 1'b1;
        set_all(3, 4);
        send_n(4);
        wait_rv(cyc);
        check("mrst_clean", 64'(data0[0]), 100);
        repeat (2) tick();

        // random traffic and backpressure
        for (int c = 0; c < 400; c++) begin
            i_valid  = 1'($urandom_range(0, 1));
            i_tready = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < COL; b++) iq[b] = $urandom;
            tick();
        end
        i_valid  = 1'b0;
        i_tready = 1'b1;
        repeat (12) tick();
        check("rand_q0_empty", 64'(q0.size()), 0);
        check("rand_q2_empty", 64'(q2.size()), 0);
        check("rand_ready", 64'(ready0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/beam_power_acc.md
Name: beam_power_acc

Overview:
Upstream feeder for the beam sorting/ranking stage. Per beam, it computes instantaneous power I^2+Q^2 for COL beams in parallel and accumulates it over ACC_LEN accepted samples. It then scales and saturates each sum to IW bits and presents the COL-wide power vector with a valid/ready handshake. Its o_data/o_rvalid drive the sort stage's i_data/i_rvalid; its i_tready comes from the sort stage's ready.

Parameters:
IW, 32, output power width per beam (unsigned)
COL, 64, number of beams processed in parallel
DW, 16, signed width of each I and Q component
ACC_LEN, 12, accepted samples per accumulation block (1..4096)
SHIFT, 0, right-shift applied to each accumulated sum before saturation

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-low reset
i_iq  in  COL x 2*DW  per-beam sample; [2*DW-1:DW]=I, [DW-1:0]=Q, two's complement
i_valid  in  1  i_iq valid
o_ready  out  1  block can accept i_iq this cycle
o_data  out  COL x IW  per-beam accumulated power
o_rvalid  out  1  o_data valid
i_tready  in  1  downstream accepts o_data

Behaviour:
- One clock domain (i_clk). Reset is synchronous and active-low on i_reset; all registers clear when i_reset=0 at a rising edge.
- Reset values: o_data=0, o_rvalid=0, o_ready=1, sample counter=0, state=ACC, pipeline valids=0, accumulators=0.
- Accept: a sample is accepted when i_valid && o_ready. i_valid gaps are allowed; the counter advances only on accept.
- Pipeline per beam:
  - S1 registers I*I and Q*Q (2*DW bits each).
  - S2 registers the sum (2*DW+1 bits, unsigned).
  - S3 accumulates into an AW-bit accumulator, AW = 2*DW+1+clog2(4096).
  - The first sample of a block loads the accumulator; later samples add to it.
- Block end: the ACC_LEN-th accepted sample is tagged "last". The tag travels with the sample; the counter wraps to 0 on that accept.
- Output register (hold): when the tagged sample leaves S3, the accumulator result moves to hold.
  - Transform: (acc >> SHIFT), saturated to 2^IW-1 if any bit above IW-1 is set.
  - Then o_rvalid=1.
- Latency: the last sample is accepted at cycle t; o_rvalid=1 from t+4 when hold is free.
- Output handshake:
  - o_data is stable while o_rvalid && !i_tready.
  - Transfer occurs on o_rvalid && i_tready; o_rvalid drops the next cycle unless a new result loads the same cycle.
  - Back-to-back blocks with i_tready=1 give one o_rvalid cycle per block.
- State machine:
  - ACC: pipeline runs. If a completed result is ready to leave S3 while hold is occupied and not draining this cycle, go to WAIT.
  - WAIT: the whole pipeline (S1..S3, counter) freezes and o_ready=0. When hold drains (i_tready=1), the result loads into hold in that same cycle and the FSM returns to ACC.
  - o_ready = (state==ACC), driven from the state register only.
- No sample is ever dropped or double-counted under backpressure.
- Simultaneous events: hold drain and new result in the same cycle means the new result loads and o_rvalid stays 1.
- ACC_LEN=1: every accepted sample is its own block.
- Extremes: I=Q=-2^(DW-1) gives a per-sample power of 2^(2*DW-1), which must not overflow S2 or S3.
- Reset mid-block discards partial sums and any held result; the next block starts clean.

Decomposition:
- Shared package beam_pkg:
  - COL, IW, DW defaults.
  - Function clog2.
  - typedef iq_t (packed 2*DW).
  - typedef pwr_t (IW).
  - Saturating-shift function sat_shr.
- Sub-module beam_power_lane: one beam's S1..S3 datapath plus scale/saturate, with shared enable/load/last controls.
  - Instantiated COL times in a generate loop.
  - Counter, FSM and handshake live in the top module.

Test Plan:
- COL=64, DW=16, IW=32, ACC_LEN=4, SHIFT=0. All beams I=3,Q=4 for 4 consecutive samples, i_tready=1 -> every o_data[b]=100; o_rvalid high exactly 1 cycle, 4 cycles after the 4th accept.
- Beam b gets I=b,Q=0, 4 samples -> o_data[b]=4*b^2 (beam 0=0, beam 63=15876); I=-b gives identical results.
- All beams I=Q=-32768, 4 samples -> exact sum 2^33, so o_data=0xFFFFFFFF. Same stimulus with SHIFT=2 -> o_data=0x80000000.
- i_tready=0 with 2 blocks streamed (blocks of 100 then 400) -> first held stable at 100; o_ready falls when block 2 completes. Then i_tready=1 for 2 cycles -> 100 then 400 transferred; o_ready returns to 1; accepted count=8.
- i_valid toggled 1,0,0,1,0,1,1 with I=1,Q=1 -> result 8 only after the 4th accept; o_ready stays 1.
- Reset asserted (i_reset=0) for 1 cycle after 2 of 4 samples -> o_rvalid=0, o_data=0. The next full block of I=3,Q=4 yields 100, not a mixed sum.
